stepgen_multi: RTL and testbench

Parametrised N-channel step waveform generator, the next generation of the single-channel pluto-style stepgen. Each channel integrates a signed velocity into a fixed-point position accumulator, emits a step on every toggle of a selectable position bit, and enforces step-hold and direction setup/hold times. Per-channel output mode selects step/dir, up/down or quadrature encoding. The block sits between the host register file (velocity, timing, mode) and the FPGA motor output pins.

---
 rtl/stepgen_pkg.sv | 24 ++
 rtl/stepgen_multi_if.sv | 27 ++
 rtl/stepgen_chan.sv | 138 +++++++++++++
 rtl/stepgen_multi.sv | 39 +++
 tb/tb_stepgen_multi.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/stepgen_pkg.sv
// Shared encodings for the multi-channel step generator.
package stepgen_pkg;

    // Per-channel sequencing state.
    typedef enum logic [1:0] {
        STATE_STEP     = 2'd0,
        STATE_DIRSETUP = 2'd1,
        STATE_DIRHOLD  = 2'd2
    } state_t;

    // Per-channel pin encoding.
    typedef enum logic [1:0] {
        MODE_STEPDIR  = 2'd0,
        MODE_UPDOWN   = 2'd1,
        MODE_QUAD     = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_t;

    // Gray-code quadrature pair {A, B} for a two-bit phase counter.
    function automatic logic [1:0] quad_encode(input logic [1:0] phase);
        return {phase[1], phase[1] ^ phase[0]};
    endfunction

endpackage

// File: rtl/stepgen_multi_if.sv
// Host-side control bus and motor pin bundle for stepgen_multi.
interface stepgen_multi_if #(
    parameter int N = 4,
    parameter int W = 12,
    parameter int F = 10,
    parameter int T = 5
);
    logic                  enable;
    logic [N*(F+1)-1:0]    velocity;
    logic [T-1:0]          dirtime;
    logic [T-1:0]          steptime;
    logic [2*N-1:0]        tap;
    logic [2*N-1:0]        mode;
    logic [N-1:0]          out_a;
    logic [N-1:0]          out_b;
    logic [N*(W+F)-1:0]    out_position;

    modport master (
        output enable, velocity, dirtime, steptime, tap, mode,
        input  out_a, out_b, out_position
    );

    modport slave (
        input  enable, velocity, dirtime, steptime, tap, mode,
        output out_a, out_b, out_position
    );
endinterface

// File: rtl/stepgen_chan.sv
// One step generator channel: velocity integrator, step/direction sequencer
// and output encoder.
module stepgen_chan
    import stepgen_pkg::*;
#(
    parameter int W = 12,
    parameter int F = 10,
    parameter int T = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [F:0]       velocity,
    input  logic [T-1:0]     dirtime,
    input  logic [T-1:0]     steptime,
    input  logic [1:0]       tap,
    input  mode_t            mode,
    output logic             out_a,
    output logic             out_b,
    output logic [W+F-1:0]   out_position
);

    localparam logic [T-1:0] TIMER_ONE = 1;

    logic [W+F-1:0] position_reg, position_next;
    logic [W+F-1:0] out_position_reg;
    logic [T-1:0]   timer_reg, timer_next;
    state_t         state_reg, state_next;
    logic           dir_reg, dir_next;
    logic           ones_reg, ones_next;
    logic           stepping_reg, stepping_next;
    logic [1:0]     phase_reg, phase_next;

    logic [W+F-1:0] xvel;
    logic [3:0]     tap_bits;
    logic           dbit;
    logic           pbit;
    logic           rev_pending;

    assign xvel        = {{(W-1){velocity[F]}}, velocity};
    assign dbit        = velocity[F];
    assign tap_bits    = position_reg[F +: 4];
    assign pbit        = tap_bits[tap];
    // Only turn around once the output has caught up with the position bit.
    assign rev_pending = (dir_reg != dbit) && (pbit == ones_reg);

    // Next-state logic: direction sequencing, step issue and integration.
    always_comb begin
        position_next = position_reg;
        timer_next    = timer_reg;
        state_next    = state_reg;
        dir_next      = dir_reg;
        ones_next     = ones_reg;
        stepping_next = stepping_reg;
        phase_next    = phase_reg;
        case (state_reg)
            STATE_DIRHOLD: begin
                if (timer_reg != '0) timer_next = timer_reg - TIMER_ONE;
                else                 state_next = STATE_STEP;
            end
            STATE_DIRSETUP: begin
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TIMER_ONE;
                end else begin
                    dir_next   = dbit;
                    timer_next = dirtime;
                    state_next = STATE_DIRHOLD;
                end
            end
            default: begin
                // Position only moves while the pin direction agrees with velocity.
                if (dir_reg == dbit) position_next = position_reg + xvel;
                if (timer_reg != '0) begin
                    timer_next = timer_reg - TIMER_ONE;
                end else if (stepping_reg) begin
                    // Guarantees at least one low tick between pulses.
                    stepping_next = 1'b0;
                end else if (rev_pending) begin
                    timer_next = dirtime;
                    state_next = STATE_DIRSETUP;
                end else if (pbit != ones_reg) begin
                    ones_next  = pbit;
                    timer_next = steptime;
                    // Quadrature has no low phase, so it never raises stepping.
                    if (mode == MODE_QUAD) begin
                        phase_next = dir_reg ? (phase_reg - 2'd1) : (phase_reg + 2'd1);
                    end else begin
                        stepping_next = 1'b1;
                    end
                end
            end
        endcase
    end

    // Channel state registers, advanced only on enable ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position_reg     <= '0;
            out_position_reg <= '0;
            timer_reg        <= '0;
            state_reg        <= STATE_STEP;
            dir_reg          <= 1'b0;
            ones_reg         <= 1'b0;
            stepping_reg     <= 1'b0;
            phase_reg        <= 2'd0;
        end else if (enable) begin
            position_reg     <= position_next;
            out_position_reg <= position_reg;
            timer_reg        <= timer_next;
            state_reg        <= state_next;
            dir_reg          <= dir_next;
            ones_reg         <= ones_next;
            stepping_reg     <= stepping_next;
            phase_reg        <= phase_next;
        end
    end

    // Pin encoding follows the current mode combinationally.
    always_comb begin
        out_a = 1'b0;
        out_b = 1'b0;
        case (mode)
            MODE_STEPDIR: begin
                out_a = stepping_reg;
                out_b = dir_reg;
            end
            MODE_UPDOWN: begin
                out_a = stepping_reg & ~dir_reg;
                out_b = stepping_reg & dir_reg;
            end
            MODE_QUAD: {out_a, out_b} = quad_encode(phase_reg);
            default: ;
        endcase
    end

    assign out_position = out_position_reg;

endmodule

// File: rtl/stepgen_multi.sv
// N-channel step generator: one stepgen_chan per channel, buses sliced per channel.
module stepgen_multi
    import stepgen_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 12,
    parameter int F = 10,
    parameter int T = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    stepgen_multi_if.slave bus
);

    logic           a_arr   [N];
    logic           b_arr   [N];
    logic [W+F-1:0] pos_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_chan
        stepgen_chan #(.W(W), .F(F), .T(T)) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .enable       (bus.enable),
            .velocity     (bus.velocity[gi*(F+1) +: F+1]),
            .dirtime      (bus.dirtime),
            .steptime     (bus.steptime),
            .tap          (bus.tap[2*gi +: 2]),
            .mode         (mode_t'(bus.mode[2*gi +: 2])),
            .out_a        (a_arr[gi]),
            .out_b        (b_arr[gi]),
            .out_position (pos_arr[gi])
        );

        assign bus.out_a[gi]                      = a_arr[gi];
        assign bus.out_b[gi]                      = b_arr[gi];
        assign bus.out_position[gi*(W+F) +: W+F]  = pos_arr[gi];
    end

endmodule

// File: tb/tb_stepgen_multi.sv
// Directed bench for stepgen_multi: step/dir, quadrature, up/down, tap scaling,
// reversal sequencing, enable freeze, async reset and position wrap.
module tb_stepgen_multi;
    import stepgen_pkg::*;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int F  = 10;
    localparam int T  = 5;
    localparam int PW = W + F;
    localparam int VW = F + 1;

    logic clk = 1'b0;
    logic reset_n;

    stepgen_multi_if #(.N(N), .W(W), .F(F), .T(T)) bus ();

    stepgen_multi #(.N(N), .W(W), .F(F), .T(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int rise_a [N];
    int rise_b [N];
    logic [N-1:0] prev_a;
    logic [N-1:0] prev_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else begin
            checks_passed++;
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic logic [PW-1:0] pos_of(input int c);
        return bus.out_position[c*PW +: PW];
    endfunction

    function automatic logic [1:0] ab_of(input int c);
        return {bus.out_a[c], bus.out_b[c]};
    endfunction

    task automatic set_chan(input int c, input int vel, input int tp, input mode_t md);
        bus.velocity[c*VW +: VW] = VW'(vel);
        bus.tap[2*c +: 2]        = 2'(tp);
        bus.mode[2*c +: 2]       = md;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            rise_a[c] = 0;
            rise_b[c] = 0;
        end
        prev_a = bus.out_a;
        prev_b = bus.out_b;
    endtask

    task automatic do_tick();
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (bus.out_a[c] && !prev_a[c]) rise_a[c]++;
            if (bus.out_b[c] && !prev_b[c]) rise_b[c]++;
        end
        prev_a = bus.out_a;
        prev_b = bus.out_b;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.enable   = 1'b0;
        bus.velocity = '0;
        bus.tap      = '0;
        bus.mode     = '0;
        bus.dirtime  = 5'd2;
        bus.steptime = 5'd1;
        set_chan(0, 256, 0, MODE_STEPDIR);
        set_chan(1, 512, 0, MODE_QUAD);
        set_chan(2, 256, 0, MODE_UPDOWN);
        set_chan(3, 256, 2, MODE_STEPDIR);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_a", bus.out_a, 0);
        check("rst_out_b", bus.out_b, 0);
        check("rst_out_position", bus.out_position, 0);

        @(negedge clk);
        reset_n    = 1'b1;
        bus.enable = 1'b1;
        clear_counts();

        // Forward run, then reversal of channels 0..2 after tick 20.
        for (int t = 1; t <= 40; t++) begin
            do_tick();
            case (t)
                3:  check("q_ab_t3", ab_of(1), 2'b01);
                4:  begin
                        check("c0_pos_t4", pos_of(0), 768);
                        check("c0_a_t4", bus.out_a[0], 0);
                    end
                5:  begin
                        check("c0_a_t5", bus.out_a[0], 1);
                        check("ud_ab_t5", ab_of(2), 2'b10);
                        check("q_ab_t5", ab_of(1), 2'b11);
                    end
                6:  check("c0_a_t6", bus.out_a[0], 1);
                7:  begin
                        check("c0_a_t7", bus.out_a[0], 0);
                        check("q_ab_t7", ab_of(1), 2'b10);
                    end
                9:  check("q_ab_t9", ab_of(1), 2'b00);
                16: check("tap2_a_t16", bus.out_a[3], 0);
                17: check("tap2_a_t17", bus.out_a[3], 1);
                20: begin
                        check("c0_steps_t20", rise_a[0], 4);
                        check("tap2_steps_t20", rise_a[3], 1);
                        check("ud_down_fwd", rise_b[2], 0);
                        check("c0_dir_fwd", bus.out_b[0], 0);
                        check("c0_pos_t20", pos_of(0), 4864);
                        check("c3_pos_t20", pos_of(3), 4864);
                    end
                21: begin
                        check("c0_ab_t21", ab_of(0), 2'b10);
                        check("q_ab_t21", ab_of(1), 2'b11);
                    end
                23: check("c0_a_t23", bus.out_a[0], 0);
                26: check("c0_dir_t26", bus.out_b[0], 0);
                27: check("c0_dir_t27", bus.out_b[0], 1);
                31: begin
                        check("c0_a_t31", bus.out_a[0], 0);
                        check("c0_steps_t31", rise_a[0], 5);
                        check("c0_pos_t31", pos_of(0), 5120);
                        check("q_ab_t31", ab_of(1), 2'b01);
                    end
                32: begin
                        check("c0_a_t32", bus.out_a[0], 1);
                        check("ud_ab_t32", ab_of(2), 2'b01);
                    end
                33: begin
                        check("c0_pos_t33", pos_of(0), 4608);
                        check("q_ab_t33", ab_of(1), 2'b00);
                    end
                35: check("q_ab_t35", ab_of(1), 2'b10);
                37: check("q_ab_t37", ab_of(1), 2'b11);
                40: begin
                        check("ud_up_total", rise_a[2], 5);
                        check("ud_down_total", rise_b[2], 3);
                    end
                default: ;
            endcase
            if (t == 20) begin
                set_chan(0, -256, 0, MODE_STEPDIR);
                set_chan(1, -512, 0, MODE_QUAD);
                set_chan(2, -256, 0, MODE_UPDOWN);
            end
        end

        // enable low freezes every register.
        bus.enable = 1'b0;
        repeat (5) do_tick();
        check("freeze_pos", pos_of(0), 2816);
        check("freeze_a0", bus.out_a[0], 1);
        check("freeze_q_ab", ab_of(1), 2'b01);

        // Asynchronous reset mid-step with enable low.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_a0", bus.out_a[0], 0);
        check("arst_b0", bus.out_b[0], 0);
        check("arst_pos0", pos_of(0), 0);
        check("arst_q_ab", ab_of(1), 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        set_chan(0, 256, 0, MODE_STEPDIR);
        set_chan(1, 512, 0, MODE_QUAD);
        set_chan(2, 256, 0, MODE_UPDOWN);
        bus.enable = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            do_tick();
            if (t == 4) begin
                check("rs_pos_t4", pos_of(0), 768);
                check("rs_a_t4", bus.out_a[0], 0);
            end
            if (t == 5) check("rs_ab_t5", ab_of(0), 2'b10);
        end

        // Wrap across 2^22 with tap=2; channel 3 in reserved mode.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_chan(0, 512, 2, MODE_STEPDIR);
        set_chan(3, 512, 2, MODE_RESERVED);
        clear_counts();
        for (int t = 1; t <= 8200; t++) begin
            do_tick();
            if (t == 8192) check("wrap_a_t8192", bus.out_a[0], 0);
            if (t == 8193) check("wrap_a_t8193", bus.out_a[0], 1);
        end
        check("wrap_steps", rise_a[0], 1024);
        check("wrap_pos", pos_of(0), 3584);
        check("rsv_a_rises", rise_a[3], 0);
        check("rsv_b_rises", rise_b[3], 0);
        check("rsv_pos", pos_of(3), 3584);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
